// File: rtl/ascon_stream_ctrl.sv
// rtl/ascon_stream_ctrl.sv - message sequencer between a host block stream and the ASCON-128 core
// Optional watchdog on WAIT_CIPHER/WAIT_TAG: define ASCON_TIMEOUT_EN.
module ascon_stream_ctrl #(
  parameter int NB_PT_BLOCKS = 4,
  parameter int TIMEOUT_CYC  = 64
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [63:0]  blk_data_i,
  input  logic         blk_valid_i,
  output logic         blk_ready_o,
  output logic         core_start_o,
  output logic [63:0]  core_data_o,
  output logic         core_data_valid_o,
  input  logic         core_wait_i,
  input  logic         core_cipher_valid_i,
  input  logic [63:0]  core_cipher_i,
  input  logic         core_end_i,
  input  logic [127:0] core_tag_i,
  output logic [63:0]  out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] tag_o,
  output logic         tag_valid_o,
  output logic         busy_o,
  output logic         err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_CORE,
    S_ISSUE,
    S_WAIT_CIPHER,
    S_WAIT_TAG
  } state_t;

  // blk_cnt value in WAIT_CIPHER of the last plaintext block; wraps to 0 when NB_PT_BLOCKS is 15.
  localparam logic [3:0] LAST_CNT = 4'(NB_PT_BLOCKS + 1);

  if (NB_PT_BLOCKS < 1 || NB_PT_BLOCKS > 15) begin : g_bad_nb
    $error("NB_PT_BLOCKS must be in 1..15");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_to
    $error("TIMEOUT_CYC must be in 1..255");
  end

  state_t      state;
  logic [3:0]  blk_cnt;
  logic        in_full;
  logic [63:0] in_data;
  logic        blk_load;

  assign blk_ready_o = busy_o & ~in_full;
  assign blk_load    = blk_valid_i & blk_ready_o;

`ifdef ASCON_TIMEOUT_EN
  logic [7:0] wdog;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state             <= S_IDLE;
      blk_cnt           <= 4'd0;
      in_full           <= 1'b0;
      in_data           <= 64'd0;
      core_start_o      <= 1'b0;
      core_data_o       <= 64'd0;
      core_data_valid_o <= 1'b0;
      out_data_o        <= 64'd0;
      out_valid_o       <= 1'b0;
      tag_o             <= 128'd0;
      tag_valid_o       <= 1'b0;
      busy_o            <= 1'b0;
`ifdef ASCON_TIMEOUT_EN
      err_o             <= 1'b0;
      wdog              <= 8'd0;
`endif
    end else begin
      core_start_o      <= 1'b0;
      core_data_valid_o <= 1'b0;

      if (blk_load) begin
        in_full <= 1'b1;
        in_data <= blk_data_i;
      end

      // A capture in WAIT_CIPHER below overrides this clear.
      if (out_valid_o && out_ready_i) out_valid_o <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start_i) begin
            state        <= S_LAUNCH;
            core_start_o <= 1'b1;
            busy_o       <= 1'b1;
            tag_valid_o  <= 1'b0;
`ifdef ASCON_TIMEOUT_EN
            err_o        <= 1'b0;
`endif
          end
        end
        S_LAUNCH: begin
          blk_cnt <= 4'd0;
          state   <= S_WAIT_CORE;
        end
        S_WAIT_CORE: begin
          // Holding plaintext back while ciphertext is pending keeps the single output entry safe.
          if (core_wait_i && in_full && (blk_cnt == 4'd0 || !out_valid_o)) begin
            state             <= S_ISSUE;
            core_data_valid_o <= 1'b1;
            core_data_o       <= in_data;
          end
        end
        S_ISSUE: begin
          in_full <= 1'b0;
          blk_cnt <= blk_cnt + 4'd1;
          state   <= (blk_cnt == 4'd0) ? S_WAIT_CORE : S_WAIT_CIPHER;
        end
        S_WAIT_CIPHER: begin
          if (core_cipher_valid_i) begin
            out_data_o  <= core_cipher_i;
            out_valid_o <= 1'b1;
            state       <= (blk_cnt == LAST_CNT) ? S_WAIT_TAG : S_WAIT_CORE;
          end
        end
        S_WAIT_TAG: begin
          if (core_end_i) begin
            tag_o       <= core_tag_i;
            tag_valid_o <= 1'b1;
            busy_o      <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
      endcase

`ifdef ASCON_TIMEOUT_EN
      // Counts only cycles that stay in a wait state; any transition restarts it.
      if ((state == S_WAIT_CIPHER && !core_cipher_valid_i) ||
          (state == S_WAIT_TAG && !core_end_i)) begin
        if (wdog == 8'(TIMEOUT_CYC - 1)) begin
          err_o   <= 1'b1;
          busy_o  <= 1'b0;
          in_full <= 1'b0;
          state   <= S_IDLE;
          wdog    <= 8'd0;
        end else begin
          wdog <= wdog + 8'd1;
        end
      end else begin
        wdog <= 8'd0;
      end
`endif
    end
  end

endmodule
